// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter: one bit per clk on ser_d, framed by ser_frame, valid/ready input.
// Optional macro SERIAL_BIT_TX_PARITY_EN appends an even-parity bit to every frame.
module serial_bit_tx #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1,
  parameter int MSB_FIRST  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             ser_d,
  output logic             ser_frame,
  output logic             busy,
  output logic             done
);

`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(FL - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [GW-1:0]    gcnt, gcnt_nxt;
  logic             d_nxt, frame_nxt, done_nxt;
`ifdef SERIAL_BIT_TX_PARITY_EN
  logic             par, par_nxt;
`endif

  function automatic logic head(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
  endfunction

  // shreg always holds the bits not yet put on ser_d, next one at the head
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  assign tx_ready = (state == IDLE) && !rst;
  assign busy     = (state != IDLE);

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    gcnt_nxt  = gcnt;
    d_nxt     = 1'b0;
    frame_nxt = 1'b0;
    done_nxt  = 1'b0;
`ifdef SERIAL_BIT_TX_PARITY_EN
    par_nxt   = par;
`endif
    case (state)
      IDLE: begin
        if (tx_valid) begin
          state_nxt = SHIFT;
          shreg_nxt = advance(tx_data);
          cnt_nxt   = '0;
          d_nxt     = head(tx_data);
          frame_nxt = 1'b1;
`ifdef SERIAL_BIT_TX_PARITY_EN
          par_nxt   = ^tx_data;
`endif
        end
      end
      SHIFT: begin
        if (cnt == CNT_LAST) begin
          done_nxt  = 1'b1;
          gcnt_nxt  = '0;
          state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
        end else begin
          cnt_nxt   = cnt + 1'b1;
          frame_nxt = 1'b1;
          d_nxt     = head(shreg);
          shreg_nxt = advance(shreg);
`ifdef SERIAL_BIT_TX_PARITY_EN
          if (cnt == DATA_LAST) d_nxt = par;
`endif
        end
      end
      GAP: begin
        if (gcnt == GAP_LAST) state_nxt = IDLE;
        else                  gcnt_nxt  = gcnt + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      ser_d     <= 1'b0;
      ser_frame <= 1'b0;
      done      <= 1'b0;
`ifdef SERIAL_BIT_TX_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      gcnt      <= gcnt_nxt;
      ser_d     <= d_nxt;
      ser_frame <= frame_nxt;
      done      <= done_nxt;
`ifdef SERIAL_BIT_TX_PARITY_EN
      par       <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx: MSB-first and LSB-first instances share stimulus and are checked
// cycle by cycle against a frame-timeline model (cycles since accept -> expected outputs).
module tb_serial_bit_tx;
  localparam int W = 8;
  localparam int G = 1;
`ifdef SERIAL_BIT_TX_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tx_valid = 1'b0;
  logic [W-1:0] tx_data = '0;
  logic         rdy_m, d_m, fr_m, busy_m, done_m;
  logic         rdy_l, d_l, fr_l, busy_l, done_l;

  always #5 clk = ~clk;

  serial_bit_tx #(.WIDTH(W), .GAP_CYCLES(G), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy_m),
    .ser_d(d_m), .ser_frame(fr_m), .busy(busy_m), .done(done_m));

  serial_bit_tx #(.WIDTH(W), .GAP_CYCLES(G), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy_l),
    .ser_d(d_l), .ser_frame(fr_l), .busy(busy_l), .done(done_l));

  int ncmp = 0;
  int nfail = 0;

  // Model: ph = clock edges since the accepting edge; bit ph-1 of the frame is on the line.
  bit           active = 1'b0;
  int           ph = 0;
  logic [W-1:0] word = '0;

  function automatic logic ref_bit(input logic [W-1:0] w, input int i, input bit msb);
    if (i >= W) return ^w;
    return msb ? w[W-1-i] : w[i];
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [W-1:0] dat);
    logic fr, em, el, dn, rdy;
    rst = r; tx_valid = v; tx_data = dat;
    @(posedge clk);
    if (r) begin
      active = 1'b0; ph = 0;
    end else if (!active) begin
      if (v) begin active = 1'b1; ph = 1; word = dat; end
      else ph = 0;
    end else begin
      ph++;
      if (ph == FL + G + 1) active = 1'b0;
    end
    fr  = active && ph >= 1 && ph <= FL;
    em  = fr ? ref_bit(word, ph - 1, 1'b1) : 1'b0;
    el  = fr ? ref_bit(word, ph - 1, 1'b0) : 1'b0;
    dn  = !r && (ph == FL + 1);
    rdy = !active && !r;
    #1;
    check("ready_m", rdy_m, rdy);      check("ready_l", rdy_l, rdy);
    check("frame_m", fr_m, fr);        check("frame_l", fr_l, fr);
    check("ser_d_m", d_m, em);         check("ser_d_l", d_l, el);
    check("done_m", done_m, dn);       check("done_l", done_l, dn);
    check("busy_m", busy_m, active);   check("busy_l", busy_l, active);
  endtask

  initial begin
    // reset for two cycles, then one word
    step(1'b1, 1'b1, 8'hA5);
    step(1'b1, 1'b1, 8'hA5);
    step(1'b0, 1'b1, 8'hA5);
    for (int i = 0; i < FL + G + 2; i++) step(1'b0, 1'b0, W'($urandom));
    step(1'b0, 1'b1, 8'h01);
    for (int i = 0; i < FL + G + 2; i++) step(1'b0, 1'b0, W'($urandom));
    // valid held high: FF then 00 back-to-back
    step(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < FL + G + 1; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < FL + G + 2; i++) step(1'b0, 1'b0, 8'h00);
    // reset after three bits, then a clean word
    step(1'b0, 1'b1, 8'hC3);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h99);
    step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h3C);
    for (int i = 0; i < FL + G + 2; i++) step(1'b0, 1'b0, 8'h00);
    // inputs wiggle while busy
    step(1'b0, 1'b1, 8'h5A);
    for (int i = 0; i < FL + G; i++) step(1'b0, 1'($urandom), W'($urandom));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);
    // parity patterns (plain frames when parity is off)
    step(1'b0, 1'b1, 8'h07);
    for (int i = 0; i < FL + G + 1; i++) step(1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 8'h03);
    for (int i = 0; i < FL + G + 1; i++) step(1'b0, 1'b0, 8'h00);
    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 2) != 0), W'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/serial_bit_tx.md
Name: serial_bit_tx

Overview:
- Parallel-to-serial transmitter that drives a single-bit data line, one bit per clk cycle, with a frame strobe.
- Intended to feed a D-flip-flop-based capture stage on the far end, which samples ser_d on its own posedge clk.
- Sits between a word-producing source (valid/ready handshake) and the serial link.

Parameters:
- WIDTH, 8, data word width in bits (>= 2).
- GAP_CYCLES, 1, idle cycles inserted after each frame before tx_ready reasserts (>= 0).
- MSB_FIRST, 1, 1 = bit WIDTH-1 transmitted first; 0 = bit 0 first.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- tx_data  input  WIDTH  word to transmit; sampled only on handshake.
- tx_valid  input  1  source has a word.
- tx_ready  output  1  block can accept a word; high only in IDLE.
- ser_d  output  1  serial data bit, registered.
- ser_frame  output  1  high while ser_d carries a valid frame bit, registered.
- busy  output  1  high in any state other than IDLE.
- done  output  1  single-cycle pulse on the first cycle after the last frame bit.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- States: IDLE, SHIFT, GAP.
- Reset (rst high at posedge) forces:
  - state = IDLE;
  - ser_d = 0, ser_frame = 0, done = 0, busy = 0;
  - bit counter = 0;
  - shift register = 0.
- tx_ready = (state == IDLE) and rst low. It is 0 while rst is high and 1 from the first cycle after reset.
- Handshake: accept when tx_valid && tx_ready at a posedge. tx_data is copied into the shift register on that edge; there is no other sampling.
- IDLE -> SHIFT on accept. On that same edge, ser_frame <= 1 and ser_d <= first bit. Latency from accept edge to first bit on ser_d: 1 cycle.
- SHIFT:
  - Emits one bit per cycle, WIDTH bits total (frame length FL = WIDTH, or WIDTH+1 with the optional feature).
  - Order set by MSB_FIRST.
  - Bit counter counts 0..FL-1.
  - tx_valid and tx_data are ignored in this state.
- At the edge ending the last frame bit:
  - ser_frame <= 0, ser_d <= 0, done <= 1 for exactly one cycle.
  - Next state is GAP if GAP_CYCLES > 0, else IDLE.
- GAP: holds ser_frame = 0 and ser_d = 0 for GAP_CYCLES cycles, then goes to IDLE.
- Throughput: minimum word-to-word spacing is FL + GAP_CYCLES + 1 cycles (the accept cycle counts as the IDLE cycle).
- If tx_valid is held high continuously, words are accepted back-to-back at that minimum spacing with no lost or duplicated words.
- ser_d is 0 whenever ser_frame is 0.
- busy = 1 in SHIFT and GAP, and 0 in IDLE.
- Reset mid-frame: the frame is abandoned on the reset edge and all outputs go to their reset values. No done pulse is issued for the abandoned word.
- Reset has priority over a simultaneous handshake. A word presented while rst is high is not accepted.
- Counter width is $clog2(WIDTH+2); the counter never wraps within a frame.

Optional Feature:
- Macro: SERIAL_BIT_TX_PARITY_EN.
- Defined:
  - One even-parity bit (XOR of all WIDTH data bits) is appended after the last data bit, with ser_frame still high, so FL = WIDTH+1.
  - done moves one cycle later accordingly.
  - Parity is computed from the word captured at accept.
- Not defined:
  - FL = WIDTH; no parity logic is present.

Test Plan:
1. Reset then single word: rst high 2 cycles, then low. Check tx_ready=1 on the first cycle after reset. Send 8'hA5 with MSB_FIRST=1 -> ser_d sequence 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept; ser_frame high for exactly those 8 cycles; done pulses once on the next cycle; tx_ready returns after 1 GAP cycle.
2. LSB-first: MSB_FIRST=0, send 8'h01 -> ser_d = 1 then seven 0s; ser_frame high 8 cycles.
3. Back-to-back: tx_valid held high with 8'hFF then 8'h00, GAP_CYCLES=1 -> accepts exactly 10 cycles apart; ser_d 8×1, 2 cycles low, 8×0; two done pulses.
4. Reset mid-frame: send 8'hC3, assert rst after 3 bits -> on the next cycle ser_frame=0 and ser_d=0; no done pulse. After rst drops, tx_ready=1 and 8'h3C transmits correctly.
5. Ignore while busy: change tx_data and toggle tx_valid during SHIFT -> the transmitted frame equals the word captured at accept; no extra accept occurs.
6. With SERIAL_BIT_TX_PARITY_EN defined: 8'h07 -> 8 data bits then parity bit 1 (frame 9 cycles); 8'h03 -> parity bit 0; done pulses on cycle 10 after accept.
